// File: rtl/demux_pkg.sv
// demux_pkg: default sizing constants and a constant-width helper for demux_param
package demux_pkg;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 4;
  localparam int DEF_DEPTH = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/demux_param_fifo.sv
// fifo_sync: single-clock FIFO with head-of-queue output, full/empty flags
module fifo_sync import demux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];
  // storage array is not reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_din;
  // read/write pointers and occupancy; push+pop together keeps the count
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/demux_param.sv
// demux_param: packs RATIO narrow lanes (first lane in MSBs) into wide words queued in a FIFO; DEMUX_FLUSH_EN adds partial-word flush and bytes_out
module demux_param import demux_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO,
  parameter int DEPTH = DEF_DEPTH,
  localparam int OUT_W = IN_W * RATIO,
  localparam int BW    = clog2(RATIO) + 1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             valid,
  input  logic [IN_W-1:0]  data_in,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out
`ifdef DEMUX_FLUSH_EN
  ,
  output logic [BW-1:0]    bytes_out
`endif
);
  localparam int CW = clog2(RATIO);
`ifdef DEMUX_FLUSH_EN
  localparam int FW = OUT_W + BW;
`else
  localparam int FW = OUT_W;
`endif
  logic [CW-1:0]    r_lane;
  logic [OUT_W-1:0] r_asm;
  logic [OUT_W-1:0] w_asm;
  logic             w_full;
  logic             w_empty;
  logic             w_take;
  logic             w_last;
  logic             w_flush;
  logic             w_push;
  logic [FW-1:0]    w_din;
  logic [FW-1:0]    w_head;
  assign in_ready = !reset && !w_full;
  assign w_take   = valid && in_ready;
  assign w_last   = w_take && r_lane == CW'(RATIO - 1);
`ifdef DEMUX_FLUSH_EN
  assign w_flush  = !valid && !reset && r_lane != '0 && !w_full;
  assign w_din    = w_flush ? {r_asm, BW'(r_lane)} : {w_asm, BW'(RATIO)};
  assign bytes_out = valid_out ? w_head[BW-1:0] : '0;
`else
  assign w_flush  = 1'b0;
  assign w_din    = w_asm;
`endif
  assign w_push    = w_last || w_flush;
  assign valid_out = !w_empty;
  assign data_out  = valid_out ? w_head[FW-1 -: OUT_W] : '0;
  // assembly register with the incoming lane dropped into its slot
  always_comb begin
    w_asm = r_asm;
    w_asm[OUT_W-1-int'(r_lane)*IN_W -: IN_W] = data_in;
  end
  // lane counter and partial word; cleared whenever a word is pushed
  always_ff @(posedge clk_4f or posedge reset)
    if (reset) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_push) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_take) begin
      r_lane <= r_lane + 1'b1;
      r_asm  <= w_asm;
    end
  fifo_sync #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk_4f),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (valid_out && ready_out),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
endmodule
